// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, q/r held until next done.
// Optional DIV_ZERO_BYPASS_EN: a zero divisor skips the iteration and finishes one cycle later.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nx;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic             w_ge;
  logic             w_zero_skip;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  assign w_accept = start && (r_state != StRun);
  assign w_last   = (r_state == StRun) && (r_cnt == CntW'(1));

`ifdef DIV_ZERO_BYPASS_EN
  assign w_zero_skip = (r_state == StRun) && (r_div == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  // r_dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge     = w_rem_sh >= {1'b0, r_div};
  assign w_rem_nx = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx = {r_dvd[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      StIdle, StDone: w_state_nx = start ? StRun : StIdle;
      StRun:          if (w_zero_skip || w_last) w_state_nx = StDone;
      default:        w_state_nx = StIdle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (r_state == StRun && !w_zero_skip) busy = 1'b1;
    if (r_state == StDone) done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dvd <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= x;
      r_div <= y;
      r_rem <= '0;
      r_cnt <= CntW'(WIDTH);
    end else if (w_zero_skip) begin
      r_q   <= '1;
      r_r   <= r_dvd;
      r_dbz <= 1'b1;
      r_cnt <= '0;
    end else if (r_state == StRun) begin
      r_rem <= w_rem_nx;
      r_dvd <= w_quo_nx;
      r_cnt <= r_cnt - CntW'(1);
      if (w_last) begin
        r_q   <= w_quo_nx;
        r_r   <= w_rem_nx;
        r_dbz <= (r_div == '0);
      end
    end
  end

  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider: the inverse operation of the team's combinational array multiplier.
- Accepts dividend x and divisor y on a start pulse and produces quotient q and remainder r.
- Computes one quotient bit per clock, so x == q*y + r and r < y whenever y != 0.
- Used by datapath blocks that must undo a product computed by the multiplier.

Parameters:
- WIDTH, 4, operand width in bits of x, y, q and r; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- start  input  1  request strobe; sampled on rising edge.
- x  input  WIDTH  dividend; sampled only on the edge where start is accepted.
- y  input  WIDTH  divisor; sampled only on the edge where start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; q, r and div_by_zero are valid while done is high.
- q  output  WIDTH  quotient.
- r  output  WIDTH  remainder.
- div_by_zero  output  1  set with done when the latched y was 0.

Behaviour:
- Reset (rst_n low): state IDLE; busy=0, done=0, q=0, r=0, div_by_zero=0; iteration counter cleared.
- Reset mid-operation aborts the division immediately; no done pulse is produced for the aborted operation.
- States and transitions:
  - IDLE: on start=1, latch x and y, clear the WIDTH+1-bit partial remainder, set counter=WIDTH, go to RUN. busy=1 from the next cycle.
  - RUN: each edge performs one restoring step:
    - rem = {rem[WIDTH-1:0], dividend MSB}; shift the dividend left by 1.
    - If rem >= {1'b0,y}: rem = rem - y and the new quotient LSB is 1; otherwise the quotient LSB is 0.
    - Decrement counter. When the counter reaches 0, register q and r, set done=1 and busy=0, go to DONE.
  - DONE: lasts exactly one cycle.
    - start=1 here is accepted: same action as in IDLE, back-to-back.
    - Otherwise go to IDLE.
    - done deasserts on the next edge.
- Latency: start accepted at edge N -> done high in the cycle following edge N+WIDTH, i.e. WIDTH cycles after acceptance.
- start while busy=1 is ignored; operands are not re-latched and the result is unaffected.
- x and y may change freely after the accepting edge.
- q, r and div_by_zero hold their last values after done until the next accepted start; they then remain stable (old values) until the new done.
- Arithmetic: unsigned only. The partial remainder is WIDTH+1 bits, so no overflow is possible. For y != 0, r < y always holds.
- Divide by zero (default build): the algorithm runs the full WIDTH cycles and naturally yields q = all ones and r = x. div_by_zero=1 with done.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: if the latched y == 0, skip RUN. Go directly to DONE at edge N+1 with q = all ones, r = x, div_by_zero=1; busy stays 0 throughout. Non-zero divisors are unaffected.
- Undefined: a zero divisor takes the normal WIDTH-cycle path with identical results and the flag set; no bypass logic is present.

Test Plan:
- WIDTH=4, x=13, y=3, start at edge N -> done high exactly in the cycle after edge N+4; q=4, r=1, div_by_zero=0; busy high for 4 cycles.
- Sweep all 16x15 operand pairs with y != 0 -> q*y + r == x and r < y for every pair; x=15, y=1 gives q=15, r=0; x=5, y=7 gives q=0, r=5.
- x=9, y=0 -> q=15, r=9, div_by_zero=1. Default build: done after 4 cycles. With DIV_ZERO_BYPASS_EN: done 1 cycle after start and busy never asserted.
- Start 13/3; pulse start with x=15, y=5 two cycles later while busy -> second request ignored; result q=4, r=1; a single done pulse.
- Back-to-back: start 13/3, then hold start=1 with x=8, y=2 during the done cycle -> first result q=4, r=1; second done 4 cycles later with q=4, r=0; no IDLE gap.
- Assert rst_n low at cycle 2 of a run -> busy, done, q, r and div_by_zero go to 0 asynchronously; no done pulse. A new start of 7/2 after release -> q=3, r=1.
